// File: rtl/latency_data_memory_pkg.sv
// Shared definitions for the wait-state data memory: FSM encoding, control-bus bit positions, sizing helper.
package latency_data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int CTRL_READ_BIT  = 1;
  localparam int CTRL_WRITE_BIT = 2;

  // Index width that never collapses to zero for tiny depths.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/latency_data_memory_timer.sv
// Loadable down-counter shared by the read and write paths; done is high while the count is zero.
module mem_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/latency_data_memory.sv
// Data memory with configurable read/write wait states, byte-lane writes, access faults and access counters.
// Handshake: enables are held until MemReady; MemReady is a one-cycle pulse, and enables still high at the edge ending it start a new access.
module latency_data_memory
  import latency_data_memory_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                InputClk,
  input  logic                rst,
  input  logic                MemReadEn,
  input  logic                MemWriteEn,
  input  logic [ADDR_W-1:0]   AddressBus,
  input  logic [DATA_W-1:0]   DataMemoryInput,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   DataMemoryOutput,
  output logic                MemReady,
  output logic                AccessFault,
  output logic [31:0]         ReadCount,
  output logic [31:0]         WriteCount,
  output state_t              fsm_state
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = clog2_min1(DEPTH);
  localparam int TMR_W  = 8;
  // A zero latency on only one path is served with one wait state; both zero selects the single-cycle mode.
  localparam int RD_EFF = (READ_LAT < 1) ? 1 : READ_LAT;
  localparam int WR_EFF = (WRITE_LAT < 1) ? 1 : WRITE_LAT;
  localparam bit ZERO_MODE = (READ_LAT == 0) && (WRITE_LAT == 0);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] word_idx;
  logic              req_any;
  logic              req_fault;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              tmr_done;

  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic [BYTES-1:0]  lat_be;
  logic              lat_rd;
  logic              lat_wr;
  logic              lat_fault;

  logic              ready_r;
  logic              fault_r;
  logic [DATA_W-1:0] dout_r;

  logic              we_en;
  logic [IDX_W-1:0]  we_idx;
  logic [DATA_W-1:0] we_data;
  logic [BYTES-1:0]  we_be;

  assign word_idx  = AddressBus >> OFF_W;
  assign req_idx   = word_idx[IDX_W-1:0];
  assign req_any   = MemReadEn || MemWriteEn;
  assign req_fault = ((AddressBus & ADDR_W'(BYTES - 1)) != '0)
                   || (word_idx >= ADDR_W'(DEPTH))
                   || (MemReadEn && MemWriteEn);
  assign accept    = !ZERO_MODE && req_any && ((state == IDLE) || (state == RESP));

  mem_wait_timer #(.W(TMR_W)) u_timer (
    .clk      (InputClk),
    .rst      (rst),
    .load     (accept),
    .load_val (MemReadEn ? TMR_W'(RD_EFF - 1) : TMR_W'(WR_EFF - 1)),
    .done     (tmr_done)
  );

  always_ff @(posedge InputClk) begin
    if (rst) begin
      state      <= IDLE;
      ready_r    <= 1'b0;
      fault_r    <= 1'b0;
      dout_r     <= '0;
      ReadCount  <= '0;
      WriteCount <= '0;
      lat_idx    <= '0;
      lat_data   <= '0;
      lat_be     <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_fault  <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      fault_r <= 1'b0;
      if (ZERO_MODE) begin
        if (MemReadEn)  ReadCount  <= ReadCount + 32'd1;
        if (MemWriteEn) WriteCount <= WriteCount + 32'd1;
      end
      case (state)
        RD_WAIT, WR_WAIT: begin
          if (tmr_done) begin
            state   <= RESP;
            ready_r <= 1'b1;
            fault_r <= lat_fault;
            if (lat_rd) dout_r <= lat_fault ? '0 : mem[lat_idx];
          end
        end
        RESP: begin
          state <= IDLE;
          if (lat_rd) ReadCount  <= ReadCount + 32'd1;
          if (lat_wr) WriteCount <= WriteCount + 32'd1;
        end
        default: ;
      endcase
      // A new request wins over the default return to IDLE.
      if (accept) begin
        state     <= MemReadEn ? RD_WAIT : WR_WAIT;
        lat_idx   <= req_idx;
        lat_data  <= DataMemoryInput;
        lat_be    <= ByteEn;
        lat_rd    <= MemReadEn;
        lat_wr    <= MemWriteEn;
        lat_fault <= req_fault;
      end
    end
  end

  assign we_en   = ZERO_MODE ? (MemWriteEn && !req_fault)
                             : ((state == RESP) && lat_wr && !lat_fault);
  assign we_idx  = ZERO_MODE ? req_idx : lat_idx;
  assign we_data = ZERO_MODE ? DataMemoryInput : lat_data;
  assign we_be   = ZERO_MODE ? ByteEn : lat_be;

  // Array has no reset so contents survive rst; a reset edge never commits.
  always_ff @(posedge InputClk) begin
    if (!rst && we_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (we_be[i]) mem[we_idx][8*i +: 8] <= we_data[8*i +: 8];
      end
    end
  end

  assign MemReady         = ZERO_MODE ? 1'b1 : ready_r;
  assign AccessFault      = ZERO_MODE ? (req_any && req_fault) : fault_r;
  assign DataMemoryOutput = ZERO_MODE ? ((MemReadEn && !req_fault) ? mem[req_idx] : '0) : dout_r;
  assign fsm_state        = state;

endmodule
